// File: rtl/ipr_write_arbiter.sv
// Round-robin arbiter sharing one IPR write port among N_REQ requesters.
// One transfer in flight at a time; completion is routed back to the granted requester.
module ipr_write_arbiter #(
  parameter int DSIZE          = 8,
  parameter int N_REQ          = 4,
  parameter int WATCHDOG_LIMIT = 100
) (
  input  logic                   w_clk,
  input  logic                   w_rst_n,
  input  logic [N_REQ-1:0]       s_req,
  input  logic [N_REQ-1:0]       s_we,
  input  logic [N_REQ*DSIZE-1:0] s_wdata,
  output logic [N_REQ-1:0]       s_gnt,
  output logic [N_REQ-1:0]       s_rvalid,
  output logic                   m_req,
  output logic                   m_we,
  output logic [DSIZE-1:0]       m_wdata,
  input  logic                   m_gnt,
  input  logic                   m_rvalid,
  output logic                   stall_timeout,
  output logic                   stall_pulse
);

  localparam int                IW       = $clog2(N_REQ);
  localparam int                PW       = IW + 1;
  localparam int                CW       = $clog2(WATCHDOG_LIMIT + 1);
  localparam logic [CW-1:0]     WD_MAX   = CW'(WATCHDOG_LIMIT);
  localparam logic [IW-1:0]     LAST_IDX = IW'(N_REQ - 1);
  localparam logic [N_REQ-1:0]  ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic {ST_ARB = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t            state_r;
  logic [IW-1:0]     rr_ptr_r;
  logic [IW-1:0]     rsp_id_r;
  logic [CW-1:0]     wd_cnt_r;
  logic              stall_timeout_r;
  logic              stall_pulse_r;

  logic [N_REQ-1:0]  elig_s;
  logic              any_s;
  logic              arb_s;
  logic              present_s;
  logic              gnt_fire_s;
  logic              rsp_fire_s;
  logic [IW-1:0]     sel_s;
  logic [IW-1:0]     rr_nxt_s;
  logic [CW-1:0]     wd_nxt_s;

  assign elig_s     = s_req & s_we;
  assign any_s      = |elig_s;
  // Gating with w_rst_n keeps every output low while reset is held.
  assign arb_s      = w_rst_n & (state_r == ST_ARB);
  assign present_s  = arb_s & any_s;
  assign gnt_fire_s = present_s & m_gnt;
  assign rsp_fire_s = w_rst_n & (state_r == ST_WAIT) & m_rvalid;
  assign rr_nxt_s   = (sel_s == LAST_IDX) ? {IW{1'b0}} : sel_s + IW'(1);

  // First eligible requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    logic          found;
    logic          hit;
    logic [PW-1:0] pos;
    sel_s = rr_ptr_r;
    found = 1'b0;
    hit   = 1'b0;
    pos   = {PW{1'b0}};
    for (int k = 0; k < N_REQ; k++) begin
      pos   = {1'b0, rr_ptr_r} + PW'(k);
      pos   = (pos >= PW'(N_REQ)) ? pos - PW'(N_REQ) : pos;
      hit   = ~found & elig_s[pos[IW-1:0]];
      sel_s = hit ? pos[IW-1:0] : sel_s;
      found = found | hit;
    end
  end

  // Downstream request, data mux, one-hot grant and routed completion.
  always_comb begin
    m_req    = 1'b0;
    m_we     = 1'b0;
    m_wdata  = {DSIZE{1'b0}};
    s_gnt    = {N_REQ{1'b0}};
    s_rvalid = {N_REQ{1'b0}};
    if (present_s) begin
      m_req   = 1'b1;
      m_we    = 1'b1;
      m_wdata = s_wdata[int'(sel_s)*DSIZE +: DSIZE];
      s_gnt   = m_gnt ? (ONE_HOT0 << sel_s) : {N_REQ{1'b0}};
    end else begin
      m_wdata = {DSIZE{1'b0}};
    end
    if (rsp_fire_s) begin
      s_rvalid = ONE_HOT0 << rsp_id_r;
    end else begin
      s_rvalid = {N_REQ{1'b0}};
    end
  end

  // Watchdog counts presented-but-refused cycles, saturating at the limit.
  always_comb begin
    if (!present_s || m_gnt) begin
      wd_nxt_s = {CW{1'b0}};
    end else if (wd_cnt_r == WD_MAX) begin
      wd_nxt_s = wd_cnt_r;
    end else begin
      wd_nxt_s = wd_cnt_r + CW'(1);
    end
  end

  // Arbitration FSM, round-robin pointer and watchdog flags.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_r         <= ST_ARB;
      rr_ptr_r        <= {IW{1'b0}};
      rsp_id_r        <= {IW{1'b0}};
      wd_cnt_r        <= {CW{1'b0}};
      stall_timeout_r <= 1'b0;
      stall_pulse_r   <= 1'b0;
    end else begin
      wd_cnt_r        <= wd_nxt_s;
      stall_timeout_r <= (wd_nxt_s == WD_MAX);
      // Pulse lines up with the first cycle stall_timeout reads high.
      stall_pulse_r   <= (wd_nxt_s == WD_MAX) & ~stall_timeout_r;
      case (state_r)
        ST_ARB: begin
          if (gnt_fire_s) begin
            rsp_id_r <= sel_s;
            rr_ptr_r <= rr_nxt_s;
            state_r  <= ST_WAIT;
          end else begin
            state_r  <= ST_ARB;
          end
        end
        ST_WAIT: begin
          if (m_rvalid) begin
            state_r <= ST_ARB;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        default: state_r <= ST_ARB;
      endcase
    end
  end

  assign stall_timeout = stall_timeout_r;
  assign stall_pulse   = stall_pulse_r;

endmodule
